// File: rtl/uart_alarm_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_alarm_rx_pkg
// Shared definitions for the UART alarm-set front end:
//   - ASCII character constants used by the frame parser
//   - range limits for hour / minute / second
//   - parser and byte-receiver state encodings
//   - small helpers for digit classification and two-digit conversion
// ---------------------------------------------------------------------------
package uart_alarm_rx_pkg;

  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam logic [6:0] MAX_HOUR = 7'd23;
  localparam logic [6:0] MAX_MIN  = 7'd59;
  localparam logic [6:0] MAX_SEC  = 7'd59;

  // Parser states. PS_CANCEL holds the frame after an 'X' while waiting
  // for the CR that confirms the cancel.
  typedef enum logic [3:0] {
    PS_IDLE,
    PS_H1,
    PS_H0,
    PS_M1,
    PS_M0,
    PS_S1,
    PS_S0,
    PS_TERM,
    PS_CANCEL
  } parse_state_t;

  // Byte receiver states. RX_PARITY is only visited in the 8E1 build.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  // Digits are stored as their low nibble (0x30..0x39 -> 0..9); the largest
  // result, 99, fits in 7 bits.
  function automatic logic [6:0] two_digit(input logic [3:0] tens,
                                           input logic [3:0] ones);
    return (7'(tens) * 7'd10) + 7'(ones);
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
// 16x oversampled UART byte receiver, LSB first.
//   Format: 8N1 by default; 8E1 when the macro UART_PARITY_EN is defined.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   rx          serial line, asynchronous to clk, idles high
//   byte_valid  one-cycle pulse, byte_data holds a good byte
//   byte_data   last good byte
//   byte_err    one-cycle pulse on framing (stop = 0) or parity error
// A start that reads high again at sample 8 is a glitch and is dropped
// without any pulse. The divisor round(CLK_FREQ/(BAUD*16)) must be >= 2.
// ---------------------------------------------------------------------------
module uart_byte_rx
  import uart_alarm_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       samp_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  rx_state_t        state;
  rx_state_t        state_next;

  logic tick;
  logic fall;
  logic start_chk;
  logic mid_bit;

`ifdef UART_PARITY_EN
  logic par_err;
`endif

  // The divider only runs while a character is in progress so that the
  // sample phase is anchored to the detected falling edge.
  assign tick      = (state != RX_IDLE) && (div_cnt == DIV_W'(DIV - 1));
  assign fall      = rx_prev & ~rx_s;
  assign start_chk = tick && (samp_cnt == 4'd7);
  // After the start re-check the sample counter is zeroed, so each later
  // 16th tick lands in the middle of the next bit.
  assign mid_bit   = tick && (samp_cnt == 4'd15);

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:   if (fall) state_next = RX_START;
      RX_START:  if (start_chk) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (mid_bit && (bit_cnt == 3'd7)) begin
`ifdef UART_PARITY_EN
          state_next = RX_PARITY;
`else
          state_next = RX_STOP;
`endif
        end
      end
      RX_PARITY: if (mid_bit) state_next = RX_STOP;
      RX_STOP:   if (mid_bit) state_next = RX_IDLE;
      default:   state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      div_cnt    <= '0;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_err   <= 1'b0;
`ifdef UART_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      state      <= state_next;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;

      if (state == RX_IDLE) begin
        div_cnt  <= '0;
        samp_cnt <= '0;
        bit_cnt  <= '0;
`ifdef UART_PARITY_EN
        par_err  <= 1'b0;
`endif
      end else if (tick) begin
        div_cnt  <= '0;
        samp_cnt <= ((state == RX_START) && (samp_cnt == 4'd7)) ? 4'd0 : samp_cnt + 4'd1;
      end else begin
        div_cnt  <= div_cnt + DIV_W'(1);
      end

      if ((state == RX_DATA) && mid_bit) begin
        shift   <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

`ifdef UART_PARITY_EN
      // Even parity: data bits plus parity bit must hold an even count of ones.
      if ((state == RX_PARITY) && mid_bit) par_err <= rx_s ^ (^shift);
`endif

      if ((state == RX_STOP) && mid_bit) begin
`ifdef UART_PARITY_EN
        if (rx_s && !par_err) begin
`else
        if (rx_s) begin
`endif
          byte_valid <= 1'b1;
          byte_data  <= shift;
        end else begin
          byte_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_alarm_rx.sv
// ---------------------------------------------------------------------------
// uart_alarm_rx
// Serial front end for the alarm block. Parses "AHHMMSS<CR>" alarm-set
// frames and "X<CR>" cancel frames received on rx.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   rx           UART line (idles high)
//   Less_uart    seconds 0..59
//   Middle_uart  minutes 0..59
//   Big_uart     hours 0..23
//   uart_sign    7'd1 while a valid alarm time is held, else 7'd0
//   frame_err    one-cycle pulse when a frame is rejected
// Optional feature: define UART_PARITY_EN for 8E1 reception (default 8N1).
// 'A' in any non-idle state restarts the frame without an error. Receive
// errors are only reported while a frame is in progress.
// ---------------------------------------------------------------------------
module uart_alarm_rx
  import uart_alarm_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [6:0] Less_uart,
  output logic [6:0] Middle_uart,
  output logic [6:0] Big_uart,
  output logic [6:0] uart_sign,
  output logic       frame_err
);

  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_err;

  parse_state_t state;
  parse_state_t state_next;
  logic [3:0]   h1, h0, m1, m0, s1, s0;
  logic [6:0]   hour_val, min_val, sec_val;
  logic         range_ok;
  logic         commit;
  logic         cancel;
  logic         err;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err)
  );

  assign hour_val = two_digit(h1, h0);
  assign min_val  = two_digit(m1, m0);
  assign sec_val  = two_digit(s1, s0);
  assign range_ok = (hour_val <= MAX_HOUR) && (min_val <= MAX_MIN) && (sec_val <= MAX_SEC);

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    cancel     = 1'b0;
    err        = 1'b0;
    if (byte_err) begin
      if (state != PS_IDLE) begin
        err        = 1'b1;
        state_next = PS_IDLE;
      end
    end else if (byte_valid) begin
      if ((state != PS_IDLE) && (byte_data == CH_A)) begin
        state_next = PS_H1;
      end else begin
        case (state)
          PS_IDLE: begin
            if (byte_data == CH_A)      state_next = PS_H1;
            else if (byte_data == CH_X) state_next = PS_CANCEL;
          end
          PS_H1, PS_H0, PS_M1, PS_M0, PS_S1, PS_S0: begin
            if (is_digit(byte_data)) begin
              case (state)
                PS_H1:   state_next = PS_H0;
                PS_H0:   state_next = PS_M1;
                PS_M1:   state_next = PS_M0;
                PS_M0:   state_next = PS_S1;
                PS_S1:   state_next = PS_S0;
                default: state_next = PS_TERM;
              endcase
            end else begin
              err        = 1'b1;
              state_next = PS_IDLE;
            end
          end
          PS_TERM: begin
            state_next = PS_IDLE;
            if ((byte_data == CH_CR) && range_ok) commit = 1'b1;
            else                                  err    = 1'b1;
          end
          PS_CANCEL: begin
            state_next = PS_IDLE;
            if (byte_data == CH_CR) cancel = 1'b1;
            else                    err    = 1'b1;
          end
          default: state_next = PS_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PS_IDLE;
      h1          <= '0;
      h0          <= '0;
      m1          <= '0;
      m0          <= '0;
      s1          <= '0;
      s0          <= '0;
      Less_uart   <= '0;
      Middle_uart <= '0;
      Big_uart    <= '0;
      uart_sign   <= '0;
      frame_err   <= 1'b0;
    end else begin
      state     <= state_next;
      frame_err <= err;
      // Digit capture only matters in the matching state; the state check
      // in the parser decides whether the frame survives.
      if (byte_valid && is_digit(byte_data)) begin
        case (state)
          PS_H1:   h1 <= byte_data[3:0];
          PS_H0:   h0 <= byte_data[3:0];
          PS_M1:   m1 <= byte_data[3:0];
          PS_M0:   m0 <= byte_data[3:0];
          PS_S1:   s1 <= byte_data[3:0];
          PS_S0:   s0 <= byte_data[3:0];
          default: ;
        endcase
      end
      // Time and sign update on the same edge so they never disagree.
      if (commit) begin
        Big_uart    <= hour_val;
        Middle_uart <= min_val;
        Less_uart   <= sec_val;
        uart_sign   <= 7'd1;
      end else if (cancel) begin
        uart_sign   <= 7'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_alarm_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_alarm_rx
// Directed bench for uart_alarm_rx. The DUT runs with a divisor of 2
// (3.2 MHz / 100 kBd / 16) so one bit lasts 32 clocks. Inputs are driven
// on the falling edge and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_alarm_rx;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CLKS = 32;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [6:0] Less_uart;
  logic [6:0] Middle_uart;
  logic [6:0] Big_uart;
  logic [6:0] uart_sign;
  logic       frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int err_seen    = 0;
  int bv_cycle    = 0;
  int last_lat    = 0;
  int rise_cnt    = 0;
  int rise_base   = 0;
  logic [6:0] prev_sign = '0;

  uart_alarm_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .Less_uart   (Less_uart),
    .Middle_uart (Middle_uart),
    .Big_uart    (Big_uart),
    .uart_sign   (uart_sign),
    .frame_err   (frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // event monitor: frame_err pulse count and byte_valid -> uart_sign latency
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frame_err) err_seen = err_seen + 1;
    if (dut.u_rx.byte_valid) bv_cycle = cyc;
    if ((uart_sign != 7'd0) && (prev_sign == 7'd0)) begin
      last_lat = cyc - bv_cycle;
      rise_cnt = rise_cnt + 1;
    end
    prev_sign = uart_sign;
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx    = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(BIT_CLKS);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      idle(BIT_CLKS);
    end
`ifdef UART_PARITY_EN
    rx = ^data;
    idle(BIT_CLKS);
`endif
    rx = stop_bit;
    idle(BIT_CLKS);
    rx = 1'b1;
  endtask

`ifdef UART_PARITY_EN
  task automatic send_byte_bad_par(input logic [7:0] data);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      idle(BIT_CLKS);
    end
    rx = ~(^data);
    idle(BIT_CLKS);
    rx = 1'b1;
    idle(BIT_CLKS);
  endtask
`endif

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic send_frame(input string s);
    send_str(s);
    send_byte(8'h0D, 1'b1);
    idle(8);
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input int observed, input int expected);
    vectors = vectors + 1;
    assert (observed === expected) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_time(input string tag, input int hh, input int mm,
                            input int ss, input int sign);
    check({tag, "_hour"}, int'(Big_uart), hh);
    check({tag, "_min"},  int'(Middle_uart), mm);
    check({tag, "_sec"},  int'(Less_uart), ss);
    check({tag, "_sign"}, int'(uart_sign), sign);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(BIT_CLKS);

    // reset values
    check_time("reset", 0, 0, 0, 0);
    check("reset_frame_err", int'(frame_err), 0);

    // plain valid frame
    rise_base = rise_cnt;
    send_frame("A123456");
    check_time("basic", 12, 34, 56, 1);
    check("basic_errs", err_seen, 0);
    check("basic_rise", rise_cnt - rise_base, 1);
    check("basic_latency", last_lat, 1);

    // out-of-range hour after reset: one error, outputs stay at reset values
    do_reset();
    send_frame("A240000");
    check("range_errs", err_seen, 1);
    check_time("range", 0, 0, 0, 0);

    // restart inside a frame, boundary maxima
    rise_base = rise_cnt;
    send_frame("A12A235959");
    check_time("restart", 23, 59, 59, 1);
    check("restart_errs", err_seen, 1);
    check("restart_latency", last_lat, 1);
    check("restart_rise", rise_cnt - rise_base, 1);

    // CR arriving in S1
    send_frame("A0700");
    check("short_errs", err_seen, 2);
    check_time("short", 23, 59, 59, 1);

    // cancel keeps the time
    send_frame("X");
    check_time("cancel", 23, 59, 59, 0);
    check("cancel_errs", err_seen, 2);

    // X followed by non-CR is an error
    send_str("XZ");
    idle(8);
    check("cancel_bad_errs", err_seen, 3);
    check("cancel_bad_sign", int'(uart_sign), 0);

    // framing error inside "A07"
    send_str("A0");
    send_byte("7", 1'b0);
    idle(2 * BIT_CLKS);
    check("framing_errs", err_seen, 4);
    send_frame("A070000");
    check_time("after_framing", 7, 0, 0, 1);
    check("after_framing_errs", err_seen, 4);

    // garbage, framing error and a glitch while idle are all silent
    send_str("Z5\r");
    send_byte(8'h41, 1'b0);
    idle(2 * BIT_CLKS);
    rx = 1'b0;
    idle(6);
    rx = 1'b1;
    idle(2 * BIT_CLKS);
    check("idle_noise_errs", err_seen, 4);
    check_time("idle_noise", 7, 0, 0, 1);
    // the framing-error 'A' above must not have opened a frame
    send_frame("000000");
    check("idle_noise_no_frame_errs", err_seen, 4);
    check_time("idle_noise_no_frame", 7, 0, 0, 1);

    // reset in the middle of a character
    rx = 1'b0;
    idle(BIT_CLKS);
    rx = 1'b1;
    idle(3 * BIT_CLKS);
    reset = 1'b1;
    rx    = 1'b1;
    idle(4);
    check_time("mid_reset", 0, 0, 0, 0);
    check("mid_reset_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    idle(2 * BIT_CLKS);
    send_frame("A101112");
    check_time("post_reset", 10, 11, 12, 1);
    check("post_reset_errs", err_seen, 4);

`ifdef UART_PARITY_EN
    // bad parity on '5' mid-frame, then clean retransmission
    send_str("A1234");
    send_byte_bad_par("5");
    idle(8);
    check("parity_errs", err_seen, 5);
    check_time("parity_held", 10, 11, 12, 1);
    send_frame("A123456");
    check_time("parity_retry", 12, 34, 56, 1);
    check("parity_retry_errs", err_seen, 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_alarm_rx.md
# uart_alarm_rx

Serial front end for the alarm block. Receives UART characters on `rx`, parses ASCII alarm-set frames of the form `A` `H` `H` `M` `M` `S` `S` `<CR>`, range-checks them and presents binary hour/minute/second on `Big_uart`/`Middle_uart`/`Less_uart` with `uart_sign` raised. The alarm block loads these values whenever its `set` is high and `uart_sign` is 1.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in baud. The 16× oversample divisor is round(`CLK_FREQ`/(`BAUD`·16)) and must be ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  UART line; asynchronous to `clk`; idles high.
- `Less_uart`  out  7  seconds, binary 0–59.
- `Middle_uart`  out  7  minutes, binary 0–59.
- `Big_uart`  out  7  hours, binary 0–23.
- `uart_sign`  out  7  7'd1 while a valid alarm time is held, 7'd0 otherwise.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- **Input synchronisation:** `rx` passes through a 2-flop synchroniser whose flops reset to 1.
- **Receiver:**
  - Format is 8N1 (8E1 with `UART_PARITY_EN`), LSB first, 16× oversampled.
  - A falling edge starts the receiver. The start bit is re-checked at sample 8; if the line is high there, the event is a glitch, receive is abandoned and nothing is reported.
  - Each data bit is taken at sample 8 of its bit period.
  - The stop bit must read 1. Otherwise the byte is a framing error: it is dropped and the parser receives an abort.
  - A good byte raises an internal `byte_valid` for one cycle with `byte_data`.
- **Parser states:** IDLE, H1, H0, M1, M0, S1, S0, TERM.
  - IDLE: `A` (0x41) moves to H1. Every other byte is ignored.
  - H1 through S0: the byte must be an ASCII digit, 0x30–0x39. The digit value is stored and the state advances.
  - S0 moves to TERM.
  - TERM: `0x0D` triggers validation; any other byte is an error.
  - Validation: hour = 10·H1+H0 ≤ 23, min ≤ 59, sec ≤ 59. On pass, commit; on fail, error.
- **Restart rule:** `A` received in any non-IDLE state restarts the frame at H1, keeps the prior outputs and does not pulse `frame_err`.
- **Error:** a non-digit in H1–S0, a non-CR in TERM, a failed range check, a framing error, or a parity error mid-frame (byte received outside IDLE) does all of the following:
  - pulses `frame_err`;
  - returns the parser to IDLE;
  - leaves the outputs unchanged.
- **Errors in IDLE:** framing or parity errors while the parser is in IDLE are silent.
- **Cancel:** `X` (0x58) followed by `<CR>` clears `uart_sign` to 0 and leaves the time outputs unchanged. A non-CR byte after `X` is an error.
- **Commit:** the time outputs take the new values and `uart_sign` becomes 7'd1. It stays 1 until cancel or reset; a later valid frame simply overwrites the time.
- **Reset values:** `Less_uart`=0, `Middle_uart`=0, `Big_uart`=0, `uart_sign`=0, `frame_err`=0. The parser goes to IDLE and the receiver to idle.
- **Reset mid-operation:** a reset asserted mid-byte or mid-frame discards all partial state.

## Timing
- `byte_valid` asserts on the cycle after the stop-bit sample.
- Commit, cancel and `frame_err` take effect on the clock edge that consumes `byte_valid` for the CR (or offending) byte. Outputs are registered and visible one cycle after `byte_valid`.
- The time outputs and `uart_sign` change on the same edge; they are never observable out of step.
- The receiver re-arms after sample 8 of the stop bit, which tolerates back-to-back characters with a 1-stop-bit gap.
- Clock-rate tolerance: ±2% baud mismatch must be received correctly.

## Configuration
- `UART_PARITY_EN` defined: 8E1. The parity bit is sampled between data and stop. On a mismatch the byte is dropped and treated as an error (`frame_err` only if the parser is outside IDLE).
- `UART_PARITY_EN` undefined: 8N1; no parity logic.

## Structure
- Shared package holds:
  - character constants: `CH_A`=0x41, `CH_X`=0x58, `CH_CR`=0x0D, `CH_0`=0x30;
  - limits: `MAX_HOUR`=23, `MAX_MIN`=59, `MAX_SEC`=59;
  - the parser state enum.
- One sub-module, `uart_byte_rx`, contains the synchroniser, oversample counter, bit FSM and optional parity. It outputs `byte_valid`, `byte_data` and `byte_err` (framing or parity). The top level contains the parser, range check and output registers.

## Test plan
- Send "A123456\r" at 9600 baud → outputs 12/34/56; `uart_sign`=1 one cycle after the CR `byte_valid`; no `frame_err`.
- Send "A240000\r" → one `frame_err` pulse; outputs and `uart_sign` unchanged (still 0 after reset).
- Send "A12A235959\r" → restart taken; outputs 23/59/59; no `frame_err`.
- Send "A0700\r" (CR arriving in S1) → `frame_err`. Then send "X\r" after a valid frame → `uart_sign`=0 with hour/min/sec retained.
- Framing error (stop bit forced 0) inside "A07" → `frame_err`, IDLE. A following "A070000\r" → 07/00/00.
- Assert `reset` mid-character → all outputs 0. The next full frame parses correctly.
- With `UART_PARITY_EN`: a bad parity bit on the digit '5' → `frame_err`; a clean retransmission succeeds.
